ad9866_gain_sequencer: RTL
==========================

AD9866_GAIN_SEQUENCER -- requirements
Module: ad9866_gain_sequencer

Interface
REQ-001 Parameter HOLDOFF, default 2048: cycles after reset release before any request, covering the SPI init program.
REQ-002 Parameter TIMEOUT, default 1024: cycles a request may wait for SPI acceptance before it is abandoned.
REQ-003 Parameter GAP, default 4 (min 2): idle cycles enforced after each SPI transfer completes.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rx_gain_in  input  6  requested RX PGA gain code from the host control path.
REQ-007 tx_gain_in  input  6  requested TX gain code from the host control path.
REQ-008 force_update  input  1  single-cycle pulse; reprogram both gains even if unchanged.
REQ-009 clear_err  input  1  clears timeout_err.
REQ-010 sen_n  input  1  SPI enable from the downstream SPI engine, same clock domain, used unsynchronised.
REQ-011 ext_rx_rqst  output  1  RX gain write request to the SPI engine.
REQ-012 rx_gain  output  6  RX gain code, stable while ext_rx_rqst is high.
REQ-013 ext_tx_rqst  output  1  TX gain write request to the SPI engine.
REQ-014 tx_gain  output  6  TX gain code, stable while ext_tx_rqst is high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout_err  output  1  sticky flag; a request was abandoned.

Function
REQ-017 Inputs rx_gain_in and tx_gain_in shall be registered once (rx_q, tx_q); all decisions use the registered copies.
REQ-018 Shadow registers rx_sent and tx_sent shall hold the last code accepted by the SPI engine.
REQ-019 force_rx and force_tx flags shall be set by force_update and cleared on acceptance of the matching request; if a set and a clear coincide, the set wins.
REQ-020 pend_rx = (rx_q != rx_sent) | force_rx; pend_tx is defined the same way from tx_q, tx_sent and force_tx.
REQ-021 FSM states: HOLDOFF, IDLE, REQ_RX, REQ_TX, WAIT_DONE, GAP_WAIT.
REQ-022 HOLDOFF: count HOLDOFF cycles, then go to IDLE.
REQ-023 IDLE: with sen_n=1 and a pending gain, go to REQ_RX or REQ_TX; rx_gain/tx_gain load rx_q/tx_q on the same edge.
REQ-024 Arbitration: when both are pending, serve the gain not served last (last_served resets to TX, so RX goes first).
REQ-025 ext_rx_rqst and ext_tx_rqst shall never be high together; each is registered and high only in its REQ state.
REQ-026 Latency: a gain change applied in IDLE with sen_n=1 shall raise the request on the 2nd rising edge after the change.
REQ-027 REQ_x: first sampled sen_n=0 is acceptance; on that edge drop the request, update x_sent from the code sent, clear force_x, go to WAIT_DONE.
REQ-028 REQ_x: if TIMEOUT cycles elapse without acceptance, drop the request, set timeout_err, go to IDLE; the gain stays pending and is retried.
REQ-029 WAIT_DONE: on sen_n=1 go to GAP_WAIT; GAP_WAIT counts GAP cycles, then go to IDLE.
REQ-030 A gain input change during REQ_x shall not alter the gain being sent; the new value becomes pending afterwards.
REQ-031 When a timeout set and clear_err coincide, the set wins.

Reset
REQ-032 While reset_n=0: state=HOLDOFF, both requests 0, rx_gain=tx_gain=0, busy=1, timeout_err=0, rx_sent=tx_sent=0, force_rx=force_tx=1, counter=0.
REQ-033 Reset asserted mid-request shall drop the request asynchronously; after release, HOLDOFF repeats and both gains are reprogrammed.

Structure
REQ-034 The state enum and the HOLDOFF/TIMEOUT/GAP defaults shall live in package ad9866_pkg.
REQ-035 One sub-module, ad9866_seq_timer, shall implement the shared load/count-down/expire counter used by HOLDOFF, TIMEOUT and GAP.

Verification
REQ-036 Reset release, model engine accepting 3 cycles after each request -> after HOLDOFF, RX request with rx_gain=0, then TX request with tx_gain=0, then idle with busy=0.
REQ-037 rx_gain_in 0x00->0x2A in IDLE -> ext_rx_rqst high at the 2nd edge with rx_gain=0x2A; dropped on the first edge sen_n=0 is sampled.
REQ-038 rx_gain_in and tx_gain_in change in the same cycle -> RX served first, then TX after at least GAP idle cycles, never overlapping.
REQ-039 Engine holds sen_n=1 -> request drops after 1024 cycles, timeout_err=1, retry follows; clear_err pulse -> timeout_err=0.
REQ-040 reset_n low while ext_tx_rqst=1 -> request goes low asynchronously; after release, HOLDOFF repeats and both gains are reprogrammed.

Source files
------------

// File: rtl/ad9866_pkg.sv
// Shared definitions for the AD9866 gain sequencer.
// Holds the sequencer state encoding, the arbitration marker, the
// default HOLDOFF/TIMEOUT/GAP cycle counts and the timer width helper.
package ad9866_pkg;

  localparam int unsigned GAIN_W      = 6;
  localparam int unsigned TIMER_W     = 16;
  localparam int unsigned HOLDOFF_DEF = 2048;
  localparam int unsigned TIMEOUT_DEF = 1024;
  localparam int unsigned GAP_DEF     = 4;

  typedef enum logic [2:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_REQ_RX,
    ST_REQ_TX,
    ST_WAIT_DONE,
    ST_GAP_WAIT
  } seq_state_e;

  typedef enum logic {
    SRV_RX,
    SRV_TX
  } served_e;

  function automatic logic [TIMER_W-1:0] to_tmr(input int unsigned n);
    return TIMER_W'(n);
  endfunction

endpackage

// File: rtl/ad9866_gain_sequencer_if.sv
// Bundle of the gain sequencer's host-side and SPI-engine-side signals.
//   master : the sequencer view (gain inputs, force/clear, sen_n in;
//            requests, gain codes, busy, timeout_err out)
//   slave  : the host / SPI engine view (mirror image)
interface ad9866_gain_sequencer_if;
  import ad9866_pkg::*;

  logic [GAIN_W-1:0] rx_gain_in;
  logic [GAIN_W-1:0] tx_gain_in;
  logic              force_update;
  logic              clear_err;
  logic              sen_n;
  logic              ext_rx_rqst;
  logic [GAIN_W-1:0] rx_gain;
  logic              ext_tx_rqst;
  logic [GAIN_W-1:0] tx_gain;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  rx_gain_in, tx_gain_in, force_update, clear_err, sen_n,
    output ext_rx_rqst, rx_gain, ext_tx_rqst, tx_gain, busy, timeout_err
  );

  modport slave (
    output rx_gain_in, tx_gain_in, force_update, clear_err, sen_n,
    input  ext_rx_rqst, rx_gain, ext_tx_rqst, tx_gain, busy, timeout_err
  );

endinterface

// File: rtl/ad9866_seq_timer.sv
// Load / count-down / expire counter shared by the HOLDOFF, TIMEOUT and
// GAP phases of the gain sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset (count clears to 0)
//   load_i       : load load_val_i on this edge (overrides counting)
//   load_val_i   : number of cycles until expiry
//   idle_o       : counter is at zero (not armed)
//   expire_o     : last cycle of the loaded interval (count == 1)
module ad9866_seq_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             idle_o,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign idle_o   = (count_q == '0);
  assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/ad9866_gain_sequencer.sv
// Forwards RX/TX gain changes from the host control path to the AD9866 SPI
// engine as single-word write requests, one at a time, with round-robin
// arbitration, a per-request acceptance timeout and an idle gap after each
// SPI transfer.
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : master modport -- rx/tx_gain_in, force_update, clear_err,
//              sen_n in; ext_rx/tx_rqst, rx/tx_gain, busy, timeout_err out
module ad9866_gain_sequencer
  import ad9866_pkg::*;
#(
  parameter int unsigned HOLDOFF = HOLDOFF_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned GAP     = GAP_DEF
) (
  input logic                     clk,
  input logic                     reset_n,
  ad9866_gain_sequencer_if.master bus
);

  // The timer sits at zero out of reset, so HOLDOFF arms it on its first
  // cycle with one less than the full count to keep the total at HOLDOFF.
  localparam int unsigned HOLD_LOAD = (HOLDOFF > 1) ? HOLDOFF - 1 : 1;

  seq_state_e        state_q, state_d;
  served_e           last_q, last_d;
  logic [GAIN_W-1:0] rx_q, tx_q;
  logic [GAIN_W-1:0] rx_sent_q, rx_sent_d, tx_sent_q, tx_sent_d;
  logic [GAIN_W-1:0] rx_gain_q, rx_gain_d, tx_gain_q, tx_gain_d;
  logic              force_rx_q, force_rx_d, force_tx_q, force_tx_d;
  logic              rx_rqst_q, rx_rqst_d, tx_rqst_q, tx_rqst_d;
  logic              err_q, err_d;
  logic              pend_rx, pend_tx;
  logic              tmr_load, tmr_idle, tmr_expire;
  logic [TIMER_W-1:0] tmr_val;

  ad9866_seq_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .idle_o     (tmr_idle),
    .expire_o   (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      rx_q <= bus.rx_gain_in;
      tx_q <= bus.tx_gain_in;
    end
  end

  assign pend_rx = (rx_q != rx_sent_q) | force_rx_q;
  assign pend_tx = (tx_q != tx_sent_q) | force_tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLDOFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLDOFF: if (tmr_expire) state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.sen_n) begin
          if (pend_rx && (!pend_tx || last_q == SRV_TX)) state_d = ST_REQ_RX;
          else if (pend_tx)                               state_d = ST_REQ_TX;
        end
      end
      ST_REQ_RX, ST_REQ_TX: begin
        if (!bus.sen_n)     state_d = ST_WAIT_DONE;
        else if (tmr_expire) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (bus.sen_n) state_d = ST_GAP_WAIT;
      ST_GAP_WAIT:  if (tmr_expire) state_d = ST_IDLE;
      default:      state_d = ST_HOLDOFF;
    endcase
  end

  always_comb begin
    rx_rqst_d  = (state_d == ST_REQ_RX);
    tx_rqst_d  = (state_d == ST_REQ_TX);
    rx_gain_d  = rx_gain_q;
    tx_gain_d  = tx_gain_q;
    last_d     = last_q;
    rx_sent_d  = rx_sent_q;
    tx_sent_d  = tx_sent_q;
    force_rx_d = force_rx_q;
    force_tx_d = force_tx_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (state_q == ST_IDLE && state_d == ST_REQ_RX) begin
      rx_gain_d = rx_q;
      last_d    = SRV_RX;
    end
    if (state_q == ST_IDLE && state_d == ST_REQ_TX) begin
      tx_gain_d = tx_q;
      last_d    = SRV_TX;
    end

    // Acceptance records the code actually sent, not the live input copy.
    if (state_q == ST_REQ_RX && !bus.sen_n) begin
      rx_sent_d  = rx_gain_q;
      force_rx_d = 1'b0;
    end
    if (state_q == ST_REQ_TX && !bus.sen_n) begin
      tx_sent_d  = tx_gain_q;
      force_tx_d = 1'b0;
    end
    if (bus.force_update) begin
      force_rx_d = 1'b1;
      force_tx_d = 1'b1;
    end

    if (bus.clear_err) err_d = 1'b0;
    if ((state_q == ST_REQ_RX || state_q == ST_REQ_TX) && state_d == ST_IDLE) begin
      err_d = 1'b1;
    end

    if (state_q == ST_HOLDOFF && tmr_idle) begin
      tmr_load = 1'b1;
      tmr_val  = to_tmr(HOLD_LOAD);
    end else if (state_d != state_q) begin
      case (state_d)
        ST_REQ_RX, ST_REQ_TX: begin
          tmr_load = 1'b1;
          tmr_val  = to_tmr(TIMEOUT);
        end
        ST_GAP_WAIT: begin
          tmr_load = 1'b1;
          tmr_val  = to_tmr(GAP);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_rqst_q  <= 1'b0;
      tx_rqst_q  <= 1'b0;
      rx_gain_q  <= '0;
      tx_gain_q  <= '0;
      last_q     <= SRV_TX;
      rx_sent_q  <= '0;
      tx_sent_q  <= '0;
      force_rx_q <= 1'b1;
      force_tx_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      rx_rqst_q  <= rx_rqst_d;
      tx_rqst_q  <= tx_rqst_d;
      rx_gain_q  <= rx_gain_d;
      tx_gain_q  <= tx_gain_d;
      last_q     <= last_d;
      rx_sent_q  <= rx_sent_d;
      tx_sent_q  <= tx_sent_d;
      force_rx_q <= force_rx_d;
      force_tx_q <= force_tx_d;
      err_q      <= err_d;
    end
  end

  assign bus.ext_rx_rqst = rx_rqst_q;
  assign bus.ext_tx_rqst = tx_rqst_q;
  assign bus.rx_gain     = rx_gain_q;
  assign bus.tx_gain     = tx_gain_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = err_q;

endmodule
